// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter: core and JTAG share a single-port memory bus.
// JTAG has priority, bounded by STARVE_MAX consecutive wins while the core waits.
module mem_bus_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        core_req,
    input  logic        core_isWr,
    input  logic [15:0] core_addr,
    input  logic [15:0] core_wdata,
    output logic        core_ack,
    output logic [15:0] core_rdata,
    input  logic        jtag_req,
    input  logic        jtag_isWr,
    input  logic [15:0] jtag_addr,
    input  logic [15:0] jtag_wdata,
    output logic        jtag_ack,
    output logic [15:0] jtag_rdata,
    input  logic        jtag_halt,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_isWr,
    output logic        mem_en,
    input  logic [15:0] mem_rdata,
    output logic [1:0]  busOwner
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;          // 1 = JTAG, 0 = core
    logic [3:0]  starve_q, starve_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_iswr_q, mem_iswr_d;
    logic        mem_en_q, mem_en_d;
    logic        core_ack_q, core_ack_d;
    logic        jtag_ack_q, jtag_ack_d;
    logic [15:0] core_rdata_q, core_rdata_d;
    logic [15:0] jtag_rdata_q, jtag_rdata_d;

    logic core_elig;
    logic grant_jtag;
    logic grant_core;

    assign core_elig  = core_req & ~jtag_halt;
    assign grant_jtag = jtag_req & (~core_elig | (starve_q < STARVE_LIM));
    assign grant_core = core_elig & ~grant_jtag;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_d     = starve_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_iswr_d   = mem_iswr_q;
        mem_en_d     = mem_en_q;
        core_ack_d   = 1'b0;
        jtag_ack_d   = 1'b0;
        core_rdata_d = core_rdata_q;
        jtag_rdata_d = jtag_rdata_q;

        case (state_q)
            S_IDLE: begin
                // Starvation count only runs while the core is actually waiting
                if (!core_elig) begin
                    starve_d = 4'd0;
                end else if (grant_jtag) begin
                    starve_d = sat_inc(starve_q);
                end else begin
                    starve_d = 4'd0;
                end

                if (grant_jtag || grant_core) begin
                    owner_d     = grant_jtag;
                    mem_addr_d  = grant_jtag ? jtag_addr  : core_addr;
                    mem_wdata_d = grant_jtag ? jtag_wdata : core_wdata;
                    mem_iswr_d  = grant_jtag ? jtag_isWr  : core_isWr;
                    mem_en_d    = 1'b1;
                    state_d     = S_ACC;
                end
            end
            S_ACC: begin
                if (!mem_iswr_q) begin
                    if (owner_q) begin
                        jtag_rdata_d = mem_rdata;
                    end else begin
                        core_rdata_d = mem_rdata;
                    end
                end
                jtag_ack_d = owner_q;
                core_ack_d = ~owner_q;
                mem_en_d   = 1'b0;
                mem_iswr_d = 1'b0;
                state_d    = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                mem_en_d   = 1'b0;
                mem_iswr_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            starve_q     <= 4'd0;
            mem_addr_q   <= 16'd0;
            mem_wdata_q  <= 16'd0;
            mem_iswr_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            core_ack_q   <= 1'b0;
            jtag_ack_q   <= 1'b0;
            core_rdata_q <= 16'd0;
            jtag_rdata_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_q     <= starve_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_iswr_q   <= mem_iswr_d;
            mem_en_q     <= mem_en_d;
            core_ack_q   <= core_ack_d;
            jtag_ack_q   <= jtag_ack_d;
            core_rdata_q <= core_rdata_d;
            jtag_rdata_q <= jtag_rdata_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_isWr   = mem_iswr_q;
    assign mem_en     = mem_en_q;
    assign core_ack   = core_ack_q;
    assign jtag_ack   = jtag_ack_q;
    assign core_rdata = core_rdata_q;
    assign jtag_rdata = jtag_rdata_q;
    assign busOwner   = (state_q == S_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios, then random traffic against
// a transaction-level reference model with its own copy of memory.
module tb_mem_bus_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        core_req, core_isWr, core_ack;
    logic [15:0] core_addr, core_wdata, core_rdata;
    logic        jtag_req, jtag_isWr, jtag_ack;
    logic [15:0] jtag_addr, jtag_wdata, jtag_rdata;
    logic        jtag_halt;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_isWr, mem_en;
    logic [1:0]  busOwner;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .rstn(rstn),
        .core_req(core_req), .core_isWr(core_isWr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
        .jtag_req(jtag_req), .jtag_isWr(jtag_isWr), .jtag_addr(jtag_addr),
        .jtag_wdata(jtag_wdata), .jtag_ack(jtag_ack), .jtag_rdata(jtag_rdata),
        .jtag_halt(jtag_halt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_isWr(mem_isWr),
        .mem_en(mem_en), .mem_rdata(mem_rdata), .busOwner(busOwner)
    );

    always #5 clk = ~clk;

    // External memory, with a side port used only to preload contents
    logic [15:0] xmem [256];
    logic        ld_en;
    logic [7:0]  ld_a;
    logic [15:0] ld_d;
    always @(posedge clk) begin
        if (mem_en && mem_isWr) xmem[mem_addr[7:0]] <= mem_wdata;
        else if (ld_en)         xmem[ld_a] <= ld_d;
    end
    assign mem_rdata = xmem[mem_addr[7:0]];

    logic [15:0] ref_mem [256];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic en, input logic wr,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input logic ca, input logic ja,
                            input logic [15:0] crd, input logic [15:0] jrd,
                            input logic [1:0] own);
        chk({tag, ".mem_en"},     16'(mem_en),   16'(en));
        chk({tag, ".mem_isWr"},   16'(mem_isWr), 16'(wr));
        chk({tag, ".mem_addr"},   mem_addr,      addr);
        chk({tag, ".mem_wdata"},  mem_wdata,     wdata);
        chk({tag, ".core_ack"},   16'(core_ack), 16'(ca));
        chk({tag, ".jtag_ack"},   16'(jtag_ack), 16'(ja));
        chk({tag, ".core_rdata"}, core_rdata,    crd);
        chk({tag, ".jtag_rdata"}, jtag_rdata,    jrd);
        chk({tag, ".busOwner"},   16'(busOwner), 16'(own));
    endtask

    // Waits (bounded) for the next ACC cycle and reports who owns it; 0 on timeout
    task automatic wait_grant(output logic [1:0] own);
        own = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_en) begin
                own = busOwner;
                return;
            end
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        ld_en = 1'b1;
        ld_a  = a;
        ld_d  = d;
        ref_mem[a] = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Reference model state
    int          m_phase;
    int          m_starve;
    logic [1:0]  m_own;
    logic [15:0] m_addr, m_wdata, m_rdc, m_rdj;
    logic        m_wr;
    logic        celig;
    logic [1:0]  win, own;
    int          cnt;
    bit          found;

    initial begin
        rstn = 1'b0; ld_en = 1'b0; ld_a = 8'd0; ld_d = 16'd0;
        core_req = 1'b0; core_isWr = 1'b0; core_addr = 16'd0; core_wdata = 16'd0;
        jtag_req = 1'b0; jtag_isWr = 1'b0; jtag_addr = 16'd0; jtag_wdata = 16'd0;
        jtag_halt = 1'b0;
        tick();
        tick();
        chk_outs("reset", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00);
        load(8'h20, 16'h1234);
        rstn = 1'b1;

        // Single JTAG write
        jtag_req = 1'b1; jtag_isWr = 1'b1; jtag_addr = 16'h0010; jtag_wdata = 16'hBEEF;
        tick();
        chk_outs("jwr_acc", 1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0, 2'b10);
        tick();
        chk_outs("jwr_ack", 0, 0, 16'h0010, 16'hBEEF, 0, 1, 16'h0, 16'h0, 2'b10);
        jtag_req = 1'b0;
        tick();
        chk_outs("jwr_idle", 0, 0, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0, 2'b00);

        // Single core read
        core_req = 1'b1; core_isWr = 1'b0; core_addr = 16'h0020; core_wdata = 16'h5555;
        tick();
        chk_outs("crd_acc", 1, 0, 16'h0020, 16'h5555, 0, 0, 16'h0, 16'h0, 2'b01);
        tick();
        chk_outs("crd_ack", 0, 0, 16'h0020, 16'h5555, 1, 0, 16'h1234, 16'h0, 2'b01);
        core_req = 1'b0;
        tick();
        chk_outs("crd_idle", 0, 0, 16'h0020, 16'h5555, 0, 0, 16'h1234, 16'h0, 2'b00);

        // Continuous contention: four JTAG grants then one core grant, repeating
        jtag_isWr = 1'b0; jtag_addr = 16'h0020;
        core_req = 1'b1; jtag_req = 1'b1;
        for (int g = 0; g < 10; g++) begin
            wait_grant(own);
            chk($sformatf("contend_g%0d", g), 16'(own), (g % 5 == 4) ? 16'd1 : 16'd2);
        end
        core_req = 1'b0; jtag_req = 1'b0;
        tick();
        tick();

        // Halt holds the core off entirely, release grants promptly
        jtag_halt = 1'b1; core_req = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (core_ack || mem_en) cnt++;
        end
        chk("halt_no_grant", 16'(cnt), 16'd0);
        jtag_halt = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (core_ack) begin
                found = 1'b1;
                break;
            end
        end
        chk("halt_release_ack", 16'(found), 16'd1);
        core_req = 1'b0;
        tick();

        // Halt rising during a core access does not abort it
        core_req = 1'b1;
        tick();
        chk("halt_mid_acc", 16'({mem_en, busOwner}), 16'b101);
        jtag_halt = 1'b1;
        tick();
        chk("halt_mid_ack", 16'(core_ack), 16'd1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (core_ack || mem_en) cnt++;
        end
        chk("halt_mid_no_regrant", 16'(cnt), 16'd0);
        core_req = 1'b0; jtag_halt = 1'b0;
        tick();

        // Reset during ACC drops the access and clears the starvation count
        core_req = 1'b1; jtag_req = 1'b1;
        for (int g = 0; g < 3; g++) begin
            wait_grant(own);
            chk($sformatf("pre_rst_g%0d", g), 16'(own), 16'd2);
        end
        rstn = 1'b0;
        tick();
        chk_outs("rst_mid", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00);
        tick();
        chk("rst_mid_no_ack", 16'({core_ack, jtag_ack}), 16'd0);
        rstn = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_grant(own);
            chk($sformatf("post_rst_g%0d", g), 16'(own), (g == 4) ? 16'd1 : 16'd2);
        end
        core_req = 1'b0; jtag_req = 1'b0;
        tick();
        tick();

        // Random traffic against the reference model
        rstn = 1'b0;
        for (int i = 0; i < 16; i++) load(8'h40 + 8'(i), 16'($urandom));
        rstn = 1'b1;
        m_phase = 0; m_starve = 0; m_own = 2'b00;
        m_addr = 16'h0; m_wdata = 16'h0; m_wr = 1'b0; m_rdc = 16'h0; m_rdj = 16'h0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (core_req && core_ack) core_req = 1'b0;
            else if (!core_req && $urandom_range(0, 2) == 0) begin
                core_req = 1'b1; core_isWr = 1'($urandom_range(0, 1));
                core_addr = {8'($urandom), 4'h4, 4'($urandom)}; core_wdata = 16'($urandom);
            end
            if (jtag_req && jtag_ack) jtag_req = 1'b0;
            else if (!jtag_req && $urandom_range(0, 2) == 0) begin
                jtag_req = 1'b1; jtag_isWr = 1'($urandom_range(0, 1));
                jtag_addr = {8'($urandom), 4'h4, 4'($urandom)}; jtag_wdata = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) jtag_halt = ~jtag_halt;

            case (m_phase)
                0: begin
                    celig = core_req && !jtag_halt;
                    win = 2'b00;
                    if (jtag_req && (!celig || m_starve < SMAX)) begin
                        win = 2'b10;
                        m_starve = celig ? ((m_starve >= 15) ? 15 : m_starve + 1) : 0;
                    end else if (celig) begin
                        win = 2'b01;
                        m_starve = 0;
                    end else begin
                        m_starve = 0;
                    end
                    if (win != 2'b00) begin
                        m_own   = win;
                        m_addr  = (win == 2'b10) ? jtag_addr  : core_addr;
                        m_wdata = (win == 2'b10) ? jtag_wdata : core_wdata;
                        m_wr    = (win == 2'b10) ? jtag_isWr  : core_isWr;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (m_wr) ref_mem[m_addr[7:0]] = m_wdata;
                    else if (m_own == 2'b10) m_rdj = ref_mem[m_addr[7:0]];
                    else m_rdc = ref_mem[m_addr[7:0]];
                    m_phase = 2;
                end
                default: m_phase = 0;
            endcase

            tick();
            chk_outs("rand", m_phase == 1, (m_phase == 1) && m_wr, m_addr, m_wdata,
                     (m_phase == 2) && (m_own == 2'b01), (m_phase == 2) && (m_own == 2'b10),
                     m_rdc, m_rdj, (m_phase == 0) ? 2'b00 : m_own);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive JTAG grants while the core is waiting (legal range 1..15).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port core_req, input, 1: core access request, held until core_ack.
REQ-005 SHALL have port core_isWr, input, 1: core access type, 1 for write, 0 for read.
REQ-006 SHALL have ports core_addr and core_wdata, input, 16 each: core address and write data.
REQ-007 SHALL have port core_ack, output, 1: one-cycle completion pulse to the core.
REQ-008 SHALL have port core_rdata, output, 16: core read data, valid while core_ack=1.
REQ-009 SHALL have ports jtag_req, jtag_isWr, jtag_addr[16], jtag_wdata[16] as inputs; jtag_ack[1] and jtag_rdata[16] as outputs: the JTAG-side equivalents of REQ-004..008.
REQ-010 SHALL have port jtag_halt, input, 1: when 1, the core is barred from new grants.
REQ-011 SHALL have ports mem_addr[16], mem_wdata[16], mem_isWr[1], mem_en[1] as outputs: the memory bus, all registered.
REQ-012 SHALL have port mem_rdata, input, 16: memory read data, valid combinationally in any cycle with mem_en=1 and mem_isWr=0.
REQ-013 SHALL have port busOwner, output, 2: current bus owner, 00 none, 01 core, 10 JTAG.

Function
REQ-014 SHALL implement FSM states IDLE, ACC, ACK, plus a registered owner bit (core or JTAG).
REQ-015 SHALL, in IDLE, evaluate requests; with no eligible request, remain in IDLE.
REQ-016 SHALL treat the core as eligible only when core_req=1 and jtag_halt=0.
REQ-017 SHALL grant JTAG when only JTAG requests, and grant the core when only the core is eligible.
REQ-018 SHALL grant JTAG when both are eligible and starveCnt<STARVE_MAX; otherwise grant the core.
REQ-019 SHALL, on a grant, latch the winner's addr, wdata and isWr into mem_addr, mem_wdata and mem_isWr, and move to ACC.
REQ-020 SHALL, in ACC, drive mem_en=1 for exactly one cycle.
REQ-021 SHALL, in ACC on a read, capture mem_rdata into the owner's rdata register, then move to ACK.
REQ-022 SHALL, in ACK, pulse the owner's ack for one cycle without arbitrating, then return to IDLE.
REQ-023 SHALL give a latency of: req sampled in IDLE at cycle N -> mem_en at N+1 -> ack at N+2; the earliest next grant is at N+3.
REQ-024 SHALL require requesters to deassert req by the clock edge ending their ack cycle; a req still high in IDLE is treated as a new request.
REQ-025 SHALL keep a 4-bit starveCnt: +1 on a JTAG grant while the core is eligible; cleared on a core grant or when the core is ineligible at an IDLE evaluation; it saturates at 15.
REQ-026 SHALL NOT abort an in-flight core access when jtag_halt rises in ACC or ACK; that access completes and is acked.
REQ-027 SHALL drive mem_en=0 and mem_isWr=0 outside ACC, while mem_addr and mem_wdata hold their last values.
REQ-028 SHALL drive busOwner=01 or 10 in ACC and ACK, and 00 in IDLE.
REQ-029 SHALL hold core_rdata and jtag_rdata until the next read for that requester; the value is undefined-free (reset 0).
REQ-030 SHALL leave rdata unchanged on writes, while still pulsing ack.

Reset
REQ-031 SHALL, when rstn=0 at a clock edge, set state=IDLE, starveCnt=0, core_ack=0, jtag_ack=0, mem_en=0, mem_isWr=0, mem_addr=0, mem_wdata=0, core_rdata=0, jtag_rdata=0 and busOwner=00.
REQ-032 SHALL, on reset asserted mid-access (in ACC or ACK), drop the access silently with no ack; requesters re-issue.

Verification
REQ-033 SHALL cover a single JTAG write: jtag_req=1, addr=0x0010, wdata=0xBEEF, isWr=1 -> mem_en=1, mem_addr=0x0010, mem_wdata=0xBEEF, mem_isWr=1 at N+1, and jtag_ack at N+2.
REQ-034 SHALL cover a single core read: core_req=1, addr=0x0020, memory returns 0x1234 -> mem_isWr=0 at N+1, core_ack=1 with core_rdata=0x1234 at N+2.
REQ-035 SHALL cover contention: core_req and jtag_req continuously high with STARVE_MAX=4 -> grant order J,J,J,J,C,J,J,J,J,C.
REQ-036 SHALL cover halt: jtag_halt=1 with core_req=1 for 20 cycles -> core_ack never pulses; jtag_halt=0 -> core_ack within 3 cycles.
REQ-037 SHALL cover halt mid-access: jtag_halt rises during a core ACC -> core_ack still pulses, and no later core grant occurs.
REQ-038 SHALL cover reset mid-access: rstn=0 during ACC -> next cycle mem_en=0, both acks=0, busOwner=00, starveCnt=0.
